rip_mmu_port_arbiter: RTL and testbench
=======================================

Name: rip_mmu_port_arbiter

Overview:
Round-robin arbiter that shares memory data port 1 (we/re/addr/din/dout/busy, byte-addressed, multi-cycle busy handshake) between NUM_REQ requesters, e.g. core LSU and a reservoir/DMA engine. It serialises one transaction at a time, drives the memory strobes for exactly one cycle, waits out the busy window, and returns read data with a one-cycle ack to the granted requester. Port 2 (instruction fetch) is untouched.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 32, data/address width
TIMEOUT_CYCLES, 15, max cycles in WAIT before error (used only with MMU_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rstn  in  1  reset: asynchronous, active-low
req  in  NUM_REQ  request per requester, held until ack
req_we  in  4*NUM_REQ  byte write enables per requester; 0 = read
req_addr  in  DATA_WIDTH*NUM_REQ  byte address per requester
req_wdata  in  DATA_WIDTH*NUM_REQ  write data per requester
ack  out  NUM_REQ  one-cycle completion pulse, one-hot
rdata  out  DATA_WIDTH  read data, valid while ack asserted
err  out  1  timeout error, pulses with ack
mem_we  out  4  to memory we_1
mem_re  out  1  to memory re_1
mem_addr  out  DATA_WIDTH  to memory addr_1
mem_din  out  DATA_WIDTH  to memory din_1
mem_dout  in  DATA_WIDTH  from memory dout_1
mem_busy  in  1  from memory busy_1

Behaviour:
- Reset (async, rstn=0): state IDLE, ack=0, err=0, rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_din=0, rr pointer gives requester 0 top priority.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req and !mem_busy, pick winner round-robin starting at (last_grant+1) mod NUM_REQ; latch index, we, addr, wdata; -> ISSUE. Otherwise stay.
- ISSUE (1 cycle): mem_addr/mem_din = latched values; latched we!=0 -> mem_we=latched we, mem_re=0; else mem_re=1, mem_we=0. -> WAIT; clear seen_busy.
- WAIT: strobes 0, mem_addr/mem_din held. mem_busy=1 sets seen_busy. When seen_busy and mem_busy=0: for reads capture mem_dout into rdata; -> RESP.
- RESP (1 cycle): ack[idx]=1; rdata holds captured value (reads) or 0 (writes); update last_grant=idx; -> IDLE.
- Strobes never asserted outside ISSUE; never two transactions outstanding.
- Latency with 3-cycle busy memory: req seen in cycle 0 -> ISSUE cycle 1 -> busy cycles 2-4 -> busy low cycle 5 -> ack cycle 6. Back-to-back: next ISSUE no earlier than cycle 8.
- Requester must hold req/we/addr/wdata stable until ack; req dropped before grant is ignored; req dropped after grant: transaction still completes and ack still pulses.
- req still high in IDLE after ack = new request (rr pointer already advanced, so another pending requester wins first).
- Single requester active: served every transaction, no stall from the pointer.
- Winner selection uses only req at the IDLE cycle; later-arriving req waits.
- Reset mid-transaction: abort immediately to reset values; in-flight memory op is not tracked.

Optional Feature:
MMU_ARB_TIMEOUT_EN: defined -> cycle counter in WAIT; if it reaches TIMEOUT_CYCLES without completion (busy never rose, or never fell), go RESP with ack[idx]=1, err=1, rdata=0. Undefined -> no counter, WAIT indefinitely, err tied 0.

Test Plan:
- Single read: req[0], we=0, addr=0x10, mem word 4 = 0xDEADBEEF -> one mem_re pulse with mem_addr=0x10, ack[0] at cycle 6, rdata=0xDEADBEEF, err=0.
- Byte write then read: req[1], we=4'b0010, addr=0x20, wdata=0x0000AB00 -> mem_we=4'b0010 one cycle; subsequent read of 0x20 returns byte1=0xAB, other bytes unchanged.
- Contention: req=2'b11 held continuously from reset -> grants alternate 0,1,0,1 over 4 transactions, ack one-hot, no overlap of strobes.
- Withdrawal: req[0] pulsed for the IDLE cycle only -> transaction completes, ack[0] still asserted once; req[1] rising during WAIT granted only after RESP.
- Reset mid-op: rstn low during WAIT -> all outputs 0 same cycle; after release, req[1] then req[0] pending -> requester 0 granted first.
- Timeout (MMU_ARB_TIMEOUT_EN defined): mem_busy forced 0 -> ack and err pulse after 15 WAIT cycles, rdata=0; macro undefined -> no ack.

Source files
------------

// File: rtl/rip_mmu_port_arbiter.sv
// rip_mmu_port_arbiter: round-robin arbiter sharing memory data port 1 between NUM_REQ requesters.
// Ports: clk/rstn (async active-low reset); req/req_we/req_addr/req_wdata are per-requester
// packed lanes held until ack; ack is a one-hot completion pulse with rdata (reads) and err
// (timeout); mem_we/mem_re/mem_addr/mem_din/mem_dout/mem_busy connect to memory port 1.
// Optional: define MMU_ARB_TIMEOUT_EN to abort a WAIT lasting TIMEOUT_CYCLES with err.
module rip_mmu_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [4*NUM_REQ-1:0]          req_we,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_addr,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          err,
  output logic [3:0]                    mem_we,
  output logic                          mem_re,
  output logic [DATA_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_din,
  input  logic [DATA_WIDTH-1:0]         mem_dout,
  input  logic                          mem_busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef MMU_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] last_q, idx_q, win, cand;
  logic [3:0] we_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic seen_q, err_q, done, tout;
  logic [CW-1:0] cnt_q;
  logic [3:0] we_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign we_a[g]    = req_we[4*g +: 4];
    assign addr_a[g]  = req_addr[DATA_WIDTH*g +: DATA_WIDTH];
    assign wdata_a[g] = req_wdata[DATA_WIDTH*g +: DATA_WIDTH];
  end
  // Scan from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    win = last_q;
    cand = last_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (req[cand]) win = cand;
    end
  end
  // Completion needs a busy window to have been observed first, since busy
  // only rises the cycle after the strobe.
  assign done = seen_q & ~mem_busy;
  // Without the timeout build this is constant 0 and the counter has no load.
  assign tout = TO_EN & (cnt_q == CW'(TIMEOUT_CYCLES - 1)) & ~done;
  assign mem_addr = addr_q;
  assign mem_din = wdata_q;
  assign rdata = rdata_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    mem_we = 4'h0;
    mem_re = 1'b0;
    ack = '0;
    err = 1'b0;
    case (state)
      IDLE: state_nx = (|req && !mem_busy) ? ISSUE : IDLE;
      ISSUE: begin
        mem_we = we_q;
        mem_re = ~|we_q;
        state_nx = WAIT;
      end
      WAIT: state_nx = (done | tout) ? RESP : WAIT;
      RESP: begin
        ack[idx_q] = 1'b1;
        err = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= IW'(NUM_REQ - 1);
      idx_q <= '0;
      we_q <= 4'h0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      seen_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (state == IDLE && state_nx == ISSUE) begin
        idx_q <= win;
        we_q <= we_a[win];
        addr_q <= addr_a[win];
        wdata_q <= wdata_a[win];
      end
      if (state == ISSUE) begin
        seen_q <= 1'b0;
        cnt_q <= '0;
      end
      if (state == WAIT) begin
        seen_q <= seen_q | mem_busy;
        cnt_q <= cnt_q + 1'b1;
        if (done | tout) begin
          rdata_q <= (done && we_q == 4'h0) ? mem_dout : '0;
          err_q <= tout;
        end
      end
      if (state == RESP) last_q <= idx_q;
    end
  end
endmodule

// File: tb/tb_rip_mmu_port_arbiter.sv
// tb_rip_mmu_port_arbiter: directed and randomized checks of the port-1 arbiter against a behavioural model.
module tb_rip_mmu_port_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] req = '0;
  logic [7:0] req_we = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [1:0] ack;
  logic [31:0] rdata, mem_addr, mem_din;
  logic [31:0] mem_dout = '0;
  logic err, mem_re, mem_busy;
  logic [3:0] mem_we;
  int cyc = 0, n_chk = 0, n_pass = 0, n_bad = 0, s_cyc = 0, blen = 3, bcnt = 0;
  bit mute = 0, mem_init = 0, prev_strobe = 0;
  logic [31:0] s_addr = '0, s_din = '0;
  logic [3:0] s_we = '0;
  logic s_re = 1'b0;
  logic [31:0] mem_arr [16];
  logic [31:0] ref_mem [16];
  logic [3:0] t_we [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wdata [2];

  rip_mmu_port_arbiter dut (
    .clk(clk), .rstn(rstn), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err), .mem_we(mem_we),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_busy(mem_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: busy for blen cycles after each strobe (never when muted).
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= (i == 4) ? 32'hDEADBEEF : 32'h11111111 * i;
      mem_init <= 1'b1;
    end
    if (bcnt > 0) bcnt <= bcnt - 1;
    if (mem_re || mem_we != 4'h0) begin
      if (mem_re) mem_dout <= mem_arr[mem_addr[5:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem_arr[mem_addr[5:2]][8*b +: 8] <= mem_din[8*b +: 8];
      bcnt <= mute ? 0 : blen;
    end
  end
  assign mem_busy = (bcnt != 0);

  // Protocol monitor: strobes exclusive and single-cycle, ack one-hot, err only with ack.
  always @(negedge clk) begin
    if (mem_re || mem_we != 4'h0) begin
      if ((mem_re && mem_we != 4'h0) || prev_strobe) n_bad++;
      s_cyc = cyc; s_addr = mem_addr; s_din = mem_din; s_we = mem_we; s_re = mem_re;
    end
    if ((ack & (ack - 2'd1)) != 2'd0 || (err && ack == 2'd0)) n_bad++;
    prev_strobe = mem_re || mem_we != 4'h0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pack();
    req_we = {t_we[1], t_we[0]};
    req_addr = {t_addr[1], t_addr[0]};
    req_wdata = {t_wdata[1], t_wdata[0]};
  endtask

  task automatic put(input int r, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    t_we[r] = we; t_addr[r] = a; t_wdata[r] = d; req[r] = 1'b1;
    pack();
  endtask

  task automatic wait_ack(input int lim, output logic [1:0] a, output int at,
                          output logic [31:0] rd, output logic e);
    a = '0; at = -1; rd = '0; e = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (ack != 2'd0) begin
        a = ack; at = cyc; rd = rdata; e = err;
        return;
      end
    end
  endtask

  function automatic int rr(input int last, input logic [1:0] r);
    for (int k = 1; k <= 2; k++) if (r[(last + k) % 2]) return (last + k) % 2;
    return 0;
  endfunction

  task automatic pulse_reset();
    @(negedge clk); rstn = 1'b0; req = '0;
    @(negedge clk); rstn = 1'b1;
  endtask

  logic [1:0] a;
  logic [31:0] rd;
  logic e;
  int at, at0, k, last, exp_w, idle, nacks;
  bit upd;
  int iss [4];
  int ackc [4];

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = (i == 4) ? 32'hDEADBEEF : 32'h11111111 * i;
    for (int r = 0; r < 2; r++) begin t_we[r] = '0; t_addr[r] = '0; t_wdata[r] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_strb_err", {err, mem_re, mem_we}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr_din", {mem_addr, mem_din}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Single read with 3-cycle busy: issue at +1, ack at +6.
    k = cyc;
    put(0, 4'h0, 32'h10, 32'h0);
    wait_ack(30, a, at, rd, e);
    req[0] = 1'b0;
    chk("t1_ack", a, 2'b01);
    chk("t1_issue_lat", s_cyc - k, 1);
    chk("t1_ack_lat", at - k, 6);
    chk("t1_strobe", {s_re, s_we, s_addr}, {1'b1, 4'h0, 32'h10});
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_err", e, 0);

    // Byte write then read-back.
    put(1, 4'b0010, 32'h20, 32'h0000AB00);
    wait_ack(30, a, at, rd, e);
    req[1] = 1'b0;
    ref_mem[8][15:8] = 8'hAB;
    chk("t2_wr_ack", a, 2'b10);
    chk("t2_wr_strobe", {s_re, s_we, s_din}, {1'b0, 4'b0010, 32'h0000AB00});
    chk("t2_wr_rdata", rd, 0);
    put(1, 4'h0, 32'h20, 32'h0);
    wait_ack(30, a, at, rd, e);
    req[1] = 1'b0;
    chk("t2_rd_ack", a, 2'b10);
    chk("t2_rd_rdata", rd, 32'h8888AB88);

    // Contention from reset: grants alternate 0,1,0,1.
    pulse_reset();
    put(0, 4'h0, 32'h04, 32'h0);
    put(1, 4'h0, 32'h0C, 32'h0);
    for (int i = 0; i < 4; i++) begin
      wait_ack(30, a, at, rd, e);
      iss[i] = s_cyc; ackc[i] = at;
      chk("t3_ack", a, (i % 2) ? 2'b10 : 2'b01);
      chk("t3_rdata", rd, (i % 2) ? 32'h33333333 : 32'h11111111);
    end
    req = '0;
    chk("t3_b2b_issue", iss[1] - ackc[0], 2);

    // Withdrawal after grant; late requester waits for RESP.
    @(negedge clk);
    put(0, 4'h0, 32'h30, 32'h0);
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    put(1, 4'h0, 32'h14, 32'h0);
    wait_ack(30, a, at0, rd, e);
    chk("t4_ack0", a, 2'b01);
    chk("t4_rdata0", rd, 32'hCCCCCCCC);
    wait_ack(30, a, at, rd, e);
    req[1] = 1'b0;
    chk("t4_ack1", a, 2'b10);
    chk("t4_late_issue", s_cyc - at0, 2);

    // Reset in WAIT clears outputs at once; pointer returns to requester 0.
    @(negedge clk);
    put(0, 4'h0, 32'h18, 32'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("t5_ack", ack, 0);
    chk("t5_strb_err", {err, mem_re, mem_we}, 0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_rdata", rdata, 0);
    req = '0;
    put(1, 4'h0, 32'h1C, 32'h0);
    @(negedge clk);
    put(0, 4'h0, 32'h24, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    wait_ack(40, a, at, rd, e);
    req[0] = 1'b0;
    chk("t5_first", a, 2'b01);
    chk("t5_rdata0", rd, 32'h99999999);
    wait_ack(40, a, at, rd, e);
    req[1] = 1'b0;
    chk("t5_second", a, 2'b10);

    // Memory never goes busy.
    @(negedge clk);
    mute = 1;
    put(0, 4'h0, 32'h08, 32'h0);
    wait_ack(40, a, at, rd, e);
`ifdef MMU_ARB_TIMEOUT_EN
    req[0] = 1'b0;
    chk("t6_ack", a, 2'b01);
    chk("t6_err", e, 1);
    chk("t6_rdata", rd, 0);
    chk("t6_lat", at - s_cyc, 16);
`else
    chk("t6_no_ack", a, 0);
`endif
    mute = 0;
    pulse_reset();

    // Randomized traffic; req changes only at ack or when nothing is pending,
    // so the model's winner is fixed between decisions.
    last = 1; exp_w = 0; idle = 0; nacks = 0;
    for (int c = 0; c < 4000 && nacks < 60; c++) begin
      @(negedge clk);
      blen = $urandom_range(4, 1);
      upd = 0;
      if (mem_re || mem_we != 4'h0)
        chk("rnd_strobe", {mem_re, mem_we, mem_addr},
            {t_we[exp_w] == 4'h0, t_we[exp_w], t_addr[exp_w]});
      if (ack != 2'd0) begin
        chk("rnd_ack", ack, (exp_w == 1) ? 2'b10 : 2'b01);
        chk("rnd_rdata", rdata, (t_we[exp_w] == 4'h0) ? ref_mem[t_addr[exp_w][5:2]] : 32'h0);
        chk("rnd_err", err, 0);
        for (int b = 0; b < 4; b++)
          if (t_we[exp_w][b]) ref_mem[t_addr[exp_w][5:2]][8*b +: 8] = t_wdata[exp_w][8*b +: 8];
        last = exp_w; req[exp_w] = 1'b0; nacks++; idle = 0; upd = 1;
      end else idle++;
      if (idle > 100) begin
        chk("rnd_stall", idle, 0);
        break;
      end
      if (upd || req == 2'd0) begin
        for (int r = 0; r < 2; r++)
          if (!req[r] && $urandom_range(1, 0) == 1)
            put(r, ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'h0,
                32'($urandom_range(15, 0)) << 2, $urandom);
        exp_w = rr(last, req);
      end
    end
    chk("rnd_count", nacks, 60);
    chk("protocol", n_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
